// File: rtl/operand_sel_unit.sv
// rtl/operand_sel_unit.sv - registered, handshaked operand selector with parallel or MSB-first serial delivery
//
// Selects one of NUM_IN packed operand channels or a built-in constant
// (all-ones, one, zero), captures it, then presents it either as a word
// (dout/dout_valid/dout_ready) or as an MSB-first bit stream
// (bit_out/bit_valid/bit_ready/bit_last) with optional leading-zero skip.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   din[NUM_IN*WIDTH]       packed channels, channel k at din[k*WIDTH +: WIDTH]
//   sel[SEL_W]              source select (<NUM_IN channel, NUM_IN ones, NUM_IN+1 one, else zero)
//   mode                    0 parallel word, 1 serial bits
//   skip_lz                 serial only: discard leading zeros
//   req_valid / req_ready   request handshake (ready only while idle)
//   dout, dout_valid, dout_ready         parallel output handshake
//   bit_out, bit_valid, bit_ready, bit_last  serial output handshake
module operand_sel_unit #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN + 3)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  input  logic                    skip_lz,
  input  logic                    req_valid,
  output logic                    req_ready,
  output logic [WIDTH-1:0]        dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    bit_out,
  output logic                    bit_valid,
  input  logic                    bit_ready,
  output logic                    bit_last
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SKIP, S_SHIFT} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  shreg, shreg_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [WIDTH-1:0]  dout_n;
  logic [WIDTH-1:0]  decoded;

  // Source decode; constants take priority only for their own codes,
  // every code above NUM_IN+1 yields zero.
  always_comb begin
    decoded = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) decoded = din[k*WIDTH +: WIDTH];
    end
    if (sel == SEL_W'(NUM_IN))
      decoded = '1;
    else if (sel == SEL_W'(NUM_IN + 1))
      decoded = WIDTH'(1);
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
    dout_n  = dout;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          shreg_n = decoded;
          cnt_n   = '0;
          if (!mode) begin
            state_n = S_HOLD;
            dout_n  = decoded;
          end else if (skip_lz && !decoded[WIDTH-1]) begin
            state_n = S_SKIP;
          end else begin
            state_n = S_SHIFT;
          end
        end
      end
      S_HOLD: begin
        if (dout_ready) state_n = S_IDLE;
      end
      S_SKIP: begin
        // Entered only with a zero MSB and cnt < WIDTH-1. Looking at the
        // bit behind the MSB lets the stream start the cycle after the last
        // discarded zero, so each zero costs exactly one idle cycle.
        shreg_n = shreg << 1;
        cnt_n   = cnt + 1'b1;
        if (shreg[WIDTH-2] || (cnt_n == CNT_LAST)) state_n = S_SHIFT;
      end
      S_SHIFT: begin
        if (bit_ready) begin
          shreg_n = shreg << 1;
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            state_n = S_IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      shreg      <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      bit_valid  <= 1'b0;
      bit_out    <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      dout       <= dout_n;
      dout_valid <= (state_n == S_HOLD);
      bit_valid  <= (state_n == S_SHIFT);
      bit_out    <= (state_n == S_SHIFT) && shreg_n[WIDTH-1];
    end
  end

  assign req_ready = (state == S_IDLE);
  assign bit_last  = (state == S_SHIFT) && (cnt == CNT_LAST);

endmodule
